// File: rtl/prince_sbox_cms_compress.sv
// ============================================================================
// Module   : prince_sbox_cms_compress
// Brief    : Two-stage share compression for a masked PRINCE S-box. Stage 1
//            is a pure glitch-barrier register of the component shares;
//            stage 2 folds NCOMP components per output bit into 3 shares.
//            Optional macro PRINCE_CMS_REFRESH_EN adds a 2*NOUT-bit rnd port
//            and refreshes the stage-2 shares on load.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prince_sbox_cms_compress #(
    parameter int NOUT  = 4,
    parameter int NCOMP = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NOUT*NCOMP-1:0] in_sh,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [NOUT*3-1:0]     out_sh,
    output logic                  out_valid,
`ifdef PRINCE_CMS_REFRESH_EN
    input  logic [2*NOUT-1:0]     rnd,
`endif
    input  logic                  out_ready
);

    localparam int c_NGROUP = NCOMP / 3;

    logic                  r_s1_valid;
    logic [NOUT*NCOMP-1:0] r_s1_data;
    logic                  r_s2_valid;
    logic [NOUT*3-1:0]     r_s2_data;

    logic                  w_in_xfer;
    logic                  w_out_xfer;
    logic                  w_s2_load;
    logic [NOUT*3-1:0]     w_comp;
    logic [NOUT*3-1:0]     w_s2_next;

    // Stage 2 may load when it is empty or is draining in this very cycle.
    assign w_out_xfer = r_s2_valid & out_ready;
    assign w_s2_load  = r_s1_valid & (~r_s2_valid | out_ready);
    assign in_ready   = ~r_s1_valid | w_s2_load;
    assign w_in_xfer  = in_valid & in_ready;

    // Share k of bit o collects every component whose index is congruent to k mod 3.
    for (genvar o = 0; o < NOUT; o++) begin : g_bit
        for (genvar k = 0; k < 3; k++) begin : g_share
            always_comb begin
                w_comp[o*3+k] = 1'b0;
                for (int g = 0; g < c_NGROUP; g++) begin
                    w_comp[o*3+k] = w_comp[o*3+k] ^ r_s1_data[o*NCOMP + 3*g + k];
                end
            end
        end
    end

`ifdef PRINCE_CMS_REFRESH_EN
    // Mask shares sum to zero per bit, so the unmasked value is preserved.
    for (genvar o = 0; o < NOUT; o++) begin : g_refresh
        assign w_s2_next[o*3+0] = w_comp[o*3+0] ^ rnd[2*o];
        assign w_s2_next[o*3+1] = w_comp[o*3+1] ^ rnd[2*o+1];
        assign w_s2_next[o*3+2] = w_comp[o*3+2] ^ rnd[2*o] ^ rnd[2*o+1];
    end
`else
    assign w_s2_next = w_comp;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            if (w_in_xfer) begin
                r_s1_valid <= 1'b1;
                r_s1_data  <= in_sh;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
        end else begin
            if (w_s2_load) begin
                r_s2_valid <= 1'b1;
                r_s2_data  <= w_s2_next;
            end else if (w_out_xfer) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign out_sh    = r_s2_data;
    assign out_valid = r_s2_valid;

endmodule

`default_nettype wire

// File: tb/tb_prince_sbox_cms_compress.sv
// ============================================================================
// Module   : tb_prince_sbox_cms_compress
// Brief    : Directed self-checking bench for prince_sbox_cms_compress.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prince_sbox_cms_compress;

    localparam int NOUT  = 4;
    localparam int NCOMP = 9;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NOUT*NCOMP-1:0] in_sh;
    logic                  in_valid;
    logic                  in_ready;
    logic [NOUT*3-1:0]     out_sh;
    logic                  out_valid;
    logic                  out_ready;
`ifdef PRINCE_CMS_REFRESH_EN
    logic [2*NOUT-1:0]     rnd;
`endif

    int errors = 0;
    int checks = 0;

    prince_sbox_cms_compress #(.NOUT(NOUT), .NCOMP(NCOMP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_sh     (in_sh),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_sh    (out_sh),
        .out_valid (out_valid),
`ifdef PRINCE_CMS_REFRESH_EN
        .rnd       (rnd),
`endif
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: share k of bit o is the XOR of components c with c mod 3 == k.
    function automatic logic [NOUT*3-1:0] model(input logic [NOUT*NCOMP-1:0] x);
        logic [NOUT*3-1:0] r;
        r = '0;
        for (int o = 0; o < NOUT; o++)
            for (int c = 0; c < NCOMP; c++)
                r[o*3 + (c % 3)] = r[o*3 + (c % 3)] ^ x[o*NCOMP + c];
        return r;
    endfunction

    function automatic logic [NOUT-1:0] in_parity(input logic [NOUT*NCOMP-1:0] x);
        logic [NOUT-1:0] p;
        p = '0;
        for (int o = 0; o < NOUT; o++)
            for (int c = 0; c < NCOMP; c++)
                p[o] = p[o] ^ x[o*NCOMP + c];
        return p;
    endfunction

    function automatic logic [NOUT-1:0] out_parity(input logic [NOUT*3-1:0] y);
        logic [NOUT-1:0] p;
        for (int o = 0; o < NOUT; o++)
            p[o] = y[o*3] ^ y[o*3+1] ^ y[o*3+2];
        return p;
    endfunction

    function automatic logic [NOUT*NCOMP-1:0] rand_vec();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[NOUT*NCOMP-1:0];
    endfunction

    // Single set in, checked two cycles later; entered and left at posedge+1.
    task automatic send_one(input string tag, input logic [NOUT*NCOMP-1:0] x,
                            input logic [NOUT*3-1:0] exp);
        in_sh     = x;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sh    = '0;
        check({tag, "_lat1_valid"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_data"}, 64'(out_sh), 64'(exp));
        @(posedge clk); #1;
        check({tag, "_drained"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic [NOUT*NCOMP-1:0] vec  [16];
    logic [NOUT*NCOMP-1:0] vec2 [4];
    logic                  ir, ov;
    logic [NOUT*3-1:0]     os;
    int                    got, sent, recv;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sh     = '0;
        out_ready = 1'b0;
`ifdef PRINCE_CMS_REFRESH_EN
        rnd       = '0;
`endif
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sh", 64'(out_sh), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_idle_valid", 64'(out_valid), 64'd0);

        // All-ones components: each share is XOR of three ones.
        send_one("ones", '1, 12'hFFF);
        // Only component 5 set per bit: lands in share 2.
        send_one("c5", {4{9'h020}}, 12'h924);
        send_one("c0c4", {4{9'h011}}, 12'h003 | 12'h018 | 12'h0C0 | 12'h600);

        // Back-to-back stream.
        for (int i = 0; i < 16; i++) vec[i] = rand_vec();
        got       = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 18; cyc++) begin
            in_valid = (cyc < 16);
            in_sh    = (cyc < 16) ? vec[cyc] : '0;
            #1;
            if (cyc < 16) check("bb_in_ready", 64'(in_ready), 64'd1);
            check("bb_out_valid", 64'(out_valid), 64'(cyc >= 2));
            if (out_valid && got < 16) begin
                check("bb_data", 64'(out_sh), 64'(model(vec[got])));
                check("bb_parity", 64'(out_parity(out_sh)), 64'(in_parity(vec[got])));
                got++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("bb_count", 64'(got), 64'd16);
        check("bb_drained", 64'(out_valid), 64'd0);

        // Backpressure: 5 stalled cycles while offering 4 sets.
        for (int i = 0; i < 4; i++) vec2[i] = rand_vec();
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
            out_ready = (cyc >= 5);
            in_valid  = (sent < 4);
            in_sh     = (sent < 4) ? vec2[sent] : '0;
            #1;
            ir = in_ready;
            ov = out_valid;
            os = out_sh;
            if (cyc >= 2 && cyc < 5) begin
                check("stall_in_ready", 64'(ir), 64'd0);
                check("stall_accepted", 64'(sent), 64'd2);
                check("stall_valid", 64'(ov), 64'd1);
                check("stall_hold", 64'(os), 64'(model(vec2[0])));
            end
            if (ov && out_ready) begin
                check("stall_order", 64'(os), 64'(model(vec2[recv])));
                recv++;
            end
            if (in_valid && ir) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("stall_recv", 64'(recv), 64'd4);
        check("stall_no_dup", 64'(out_valid), 64'd0);

        // Reset with both stages occupied.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sh     = '1;
        @(posedge clk); #1;
        in_sh = {4{9'h020}};
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sh    = '0;
        check("full_in_ready", 64'(in_ready), 64'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_sh", 64'(out_sh), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(posedge clk); #1;
            check("arst_no_stale", 64'(out_valid), 64'd0);
        end

`ifdef PRINCE_CMS_REFRESH_EN
        rnd = 8'hFF;
        send_one("refresh", '0, 12'h6DB);
        rnd = '0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
